// File: rtl/fifo_ui_pkg.sv
// Shared types and sizing helpers for the FIFO push-button front end.
// Used by the button debouncer and the top-level dispatcher.
package fifo_ui_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DEB_ON  = 3'd1,
        FIRE    = 3'd2,
        HELD    = 3'd3,
        DEB_OFF = 3'd4
    } deb_state_e;

    // Number of bits needed to hold any value in 0..max_val (at least one bit)
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        if (max_val < 32'd2) begin
            w = 32'd1;
        end else begin
            w = $clog2(max_val + 32'd1);
        end
        return w;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus tick-sampled debounce FSM for one push-button.
// fire is high for exactly one clock per accepted press.
module button_debounce
    import fifo_ui_pkg::*;
#(
    parameter int unsigned DEBOUNCE_SAMPLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic tick,
    input  logic btn,
    output logic fire
);

    localparam int unsigned    CW       = cnt_width(DEBOUNCE_SAMPLES);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_SAMPLES);

    logic [1:0]    sync_r;
    logic          level_s;
    logic          armed_r;
    deb_state_e    state_r;
    deb_state_e    state_next_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_next_s;
    logic [CW-1:0] cnt_inc_s;

    // Two-stage synchroniser for the asynchronous button
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], btn};
        end
    end

    assign level_s   = sync_r[1];
    assign cnt_inc_s = cnt_r + CNT_ONE;

    // A button held through reset must be seen released before it can fire
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            armed_r <= 1'b0;
        end else if (tick && !level_s) begin
            armed_r <= 1'b1;
        end else begin
            armed_r <= armed_r;
        end
    end

    // FSM state and sample counter registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Next-state logic; FIRE lasts one clock regardless of tick
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (tick && level_s && armed_r) begin
                    if (CNT_ONE == CNT_LAST) begin
                        state_next_s = FIRE;
                    end else begin
                        state_next_s = DEB_ON;
                        cnt_next_s   = CNT_ONE;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            DEB_ON: begin
                if (!tick) begin
                    state_next_s = DEB_ON;
                end else if (!level_s) begin
                    state_next_s = IDLE;
                end else if (cnt_inc_s == CNT_LAST) begin
                    state_next_s = FIRE;
                end else begin
                    cnt_next_s   = cnt_inc_s;
                end
            end
            FIRE: begin
                state_next_s = HELD;
            end
            HELD: begin
                if (tick && !level_s) begin
                    if (CNT_ONE == CNT_LAST) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = DEB_OFF;
                        cnt_next_s   = CNT_ONE;
                    end
                end else begin
                    state_next_s = HELD;
                end
            end
            DEB_OFF: begin
                if (!tick) begin
                    state_next_s = DEB_OFF;
                end else if (level_s) begin
                    state_next_s = HELD;
                end else if (cnt_inc_s == CNT_LAST) begin
                    state_next_s = IDLE;
                end else begin
                    cnt_next_s   = cnt_inc_s;
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = {CW{1'b0}};
            end
        endcase
    end

    // Press event decode
    always_comb begin
        fire = (state_r == FIRE);
    end

endmodule

// File: rtl/fifo_button_ctrl.sv
// Push-button front end for the 4-bit FIFO: debounces write/read buttons and
// issues single-clock write/read strobes with captured switch data.
module fifo_button_ctrl
    import fifo_ui_pkg::*;
#(
    parameter int unsigned WIDTH            = 4,
    parameter int unsigned TICK_DIV         = 65536,
    parameter int unsigned DEBOUNCE_SAMPLES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             btn_write,
    input  logic             btn_read,
    input  logic [WIDTH-1:0] sw_data,
    input  logic             fifo_full,
    input  logic             fifo_empty,
    output logic             write,
    output logic             read,
    output logic [WIDTH-1:0] fifo_in,
    output logic             reject
);

    localparam int unsigned   TW        = cnt_width(TICK_DIV - 32'd1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 32'd1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);

    logic [TW-1:0]    tick_cnt_r;
    logic             tick_s;
    logic [WIDTH-1:0] sw_meta_r;
    logic [WIDTH-1:0] sw_sync_r;
    logic             fire_wr_s;
    logic             fire_rd_s;
    logic             write_go_s;
    logic             read_go_s;
    logic             reject_go_s;
    logic             write_r;
    logic             read_r;
    logic             reject_r;
    logic [WIDTH-1:0] fifo_in_r;

    // Debounce sample-tick divider
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tick_cnt_r <= {TW{1'b0}};
        end else if (tick_s) begin
            tick_cnt_r <= {TW{1'b0}};
        end else begin
            tick_cnt_r <= tick_cnt_r + TICK_ONE;
        end
    end

    assign tick_s = (tick_cnt_r == TICK_LAST);

    // Two-stage synchroniser for the data switches
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sw_meta_r <= {WIDTH{1'b0}};
            sw_sync_r <= {WIDTH{1'b0}};
        end else begin
            sw_meta_r <= sw_data;
            sw_sync_r <= sw_meta_r;
        end
    end

    button_debounce #(
        .DEBOUNCE_SAMPLES (DEBOUNCE_SAMPLES)
    ) u_deb_write (
        .clock (clock),
        .reset (reset),
        .tick  (tick_s),
        .btn   (btn_write),
        .fire  (fire_wr_s)
    );

    button_debounce #(
        .DEBOUNCE_SAMPLES (DEBOUNCE_SAMPLES)
    ) u_deb_read (
        .clock (clock),
        .reset (reset),
        .tick  (tick_s),
        .btn   (btn_read),
        .fire  (fire_rd_s)
    );

    // Dispatch decision; a simultaneous write+read bypasses the flags
    always_comb begin
        write_go_s  = fire_wr_s & (fire_rd_s | ~fifo_full);
        read_go_s   = fire_rd_s & (fire_wr_s | ~fifo_empty);
        reject_go_s = (fire_wr_s & ~fire_rd_s & fifo_full) |
                      (fire_rd_s & ~fire_wr_s & fifo_empty);
    end

    // Registered strobes and write data
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            write_r   <= 1'b0;
            read_r    <= 1'b0;
            reject_r  <= 1'b0;
            fifo_in_r <= {WIDTH{1'b0}};
        end else begin
            write_r   <= write_go_s;
            read_r    <= read_go_s;
            reject_r  <= reject_go_s;
            fifo_in_r <= write_go_s ? sw_sync_r : fifo_in_r;
        end
    end

    assign write   = write_r;
    assign read    = read_r;
    assign reject  = reject_r;
    assign fifo_in = fifo_in_r;

endmodule
